// File: rtl/tmboc_code_nco_gen.sv
// Local-code generator for B1C: code NCO, chip/TMBOC-block counters and PRN
// memory read port, with a two-stage output pipeline and BPSK/BOC/TMBOC modulation.
module tmboc_code_nco_gen #(
    parameter int ACC_WIDTH      = 32,
    parameter int CHIP_IDX_WIDTH = 14,
    parameter int CODE_LEN       = 10230,
    parameter int EPOCH_WIDTH    = 8
) (
    input  logic                      rx_clk,
    input  logic                      rx_rst,
    input  logic                      rx_en,
    input  logic [ACC_WIDTH-1:0]      rx_code_fcw,
    input  logic [1:0]                rx_mod_mode,
    input  logic                      rx_load,
    input  logic [CHIP_IDX_WIDTH-1:0] rx_load_chip,
    input  logic [ACC_WIDTH-1:0]      rx_load_frac,
    input  logic [5:0]                rx_load_blk,
    output logic [CHIP_IDX_WIDTH-1:0] tx_rom_addr,
    input  logic                      rx_rom_data,
    output logic                      tx_prn,
    output logic                      tx_sig,
    output logic                      tx_vld,
    output logic [CHIP_IDX_WIDTH-1:0] tx_chip_idx,
    output logic                      tx_epoch,
    output logic [EPOCH_WIDTH-1:0]    tx_epoch_cnt,
    output logic                      tx_load_err
);

    localparam logic [CHIP_IDX_WIDTH:0]   CODE_LEN_W = (CHIP_IDX_WIDTH+1)'(CODE_LEN);
    localparam logic [CHIP_IDX_WIDTH-1:0] LAST_CHIP  = CHIP_IDX_WIDTH'(CODE_LEN - 1);
    localparam int                        NUM_S_SLOTS = 4;
    // Block positions that carry the BOC(6,1) component in TMBOC
    localparam logic [NUM_S_SLOTS*6-1:0]  S_SLOTS = {6'd29, 6'd6, 6'd4, 6'd0};

    logic [ACC_WIDTH-1:0]      acc_reg, acc_next;
    logic [CHIP_IDX_WIDTH-1:0] chip_idx_reg, chip_idx_next;
    logic [5:0]                blk_reg, blk_next;
    logic [EPOCH_WIDTH-1:0]    epoch_cnt_reg, epoch_cnt_next;
    logic                      epoch_reg, epoch_next;
    logic                      load_err_reg;

    logic [ACC_WIDTH:0]        acc_sum;
    logic                      load_ok;
    logic                      load_bad;

    logic                      boc1_sub;
    logic                      boc6_sub;
    logic [NUM_S_SLOTS-1:0]    s_slot_hit;
    logic                      sub;

    logic                      sub1_reg;
    logic [CHIP_IDX_WIDTH-1:0] chip1_reg;
    logic                      epoch1_reg;
    logic [EPOCH_WIDTH-1:0]    cnt1_reg;
    logic                      vld1_reg;

    logic                      prn2_reg;
    logic                      sig2_reg;
    logic [CHIP_IDX_WIDTH-1:0] chip2_reg;
    logic                      epoch2_reg;
    logic [EPOCH_WIDTH-1:0]    cnt2_reg;
    logic                      vld2_reg;

    assign acc_sum  = {1'b0, acc_reg} + {1'b0, rx_code_fcw};
    assign load_ok  = rx_load && ({1'b0, rx_load_chip} < CODE_LEN_W) && (rx_load_blk <= 6'd32);
    assign load_bad = rx_load && !load_ok;

    always_comb begin
        acc_next       = acc_reg;
        chip_idx_next  = chip_idx_reg;
        blk_next       = blk_reg;
        epoch_cnt_next = epoch_cnt_reg;
        epoch_next     = 1'b0;
        if (load_ok) begin
            acc_next      = rx_load_frac;
            chip_idx_next = rx_load_chip;
            blk_next      = rx_load_blk;
        end else if (rx_en) begin
            acc_next = acc_sum[ACC_WIDTH-1:0];
            if (acc_sum[ACC_WIDTH]) begin
                blk_next = (blk_reg == 6'd32) ? 6'd0 : blk_reg + 6'd1;
                if (chip_idx_reg == LAST_CHIP) begin
                    chip_idx_next  = '0;
                    epoch_next     = 1'b1;
                    epoch_cnt_next = epoch_cnt_reg + 1'b1;
                end else begin
                    chip_idx_next = chip_idx_reg + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            acc_reg       <= '0;
            chip_idx_reg  <= '0;
            blk_reg       <= '0;
            epoch_cnt_reg <= '0;
            epoch_reg     <= 1'b0;
            load_err_reg  <= 1'b0;
        end else begin
            acc_reg       <= acc_next;
            chip_idx_reg  <= chip_idx_next;
            blk_reg       <= blk_next;
            epoch_cnt_reg <= epoch_cnt_next;
            epoch_reg     <= epoch_next;
            load_err_reg  <= load_bad;
        end
    end

    // BOC(6,1): 12 half-periods per chip from the top 8 phase bits
    assign boc1_sub = acc_reg[ACC_WIDTH-1];
    assign boc6_sub = 1'(({4'b0, acc_reg[ACC_WIDTH-1 -: 8]} * 12'd12) >> 8);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_S_SLOTS; gi++) begin : g_s_slot
            assign s_slot_hit[gi] = (blk_reg == S_SLOTS[gi*6 +: 6]);
        end
    endgenerate

    always_comb begin
        sub = 1'b0;
        case (rx_mod_mode)
            2'd1:    sub = boc1_sub;
            2'd2:    sub = boc6_sub;
            2'd3:    sub = (|s_slot_hit) ? boc6_sub : boc1_sub;
            default: sub = 1'b0;
        endcase
    end

    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            sub1_reg   <= 1'b0;
            chip1_reg  <= '0;
            epoch1_reg <= 1'b0;
            cnt1_reg   <= '0;
            vld1_reg   <= 1'b0;
            prn2_reg   <= 1'b0;
            sig2_reg   <= 1'b0;
            chip2_reg  <= '0;
            epoch2_reg <= 1'b0;
            cnt2_reg   <= '0;
            vld2_reg   <= 1'b0;
        end else begin
            sub1_reg   <= sub;
            chip1_reg  <= chip_idx_reg;
            epoch1_reg <= epoch_reg;
            cnt1_reg   <= epoch_cnt_reg;
            vld1_reg   <= rx_en;
            // PRN memory answers the address presented one cycle earlier
            prn2_reg   <= rx_rom_data;
            sig2_reg   <= rx_rom_data ^ sub1_reg;
            chip2_reg  <= chip1_reg;
            epoch2_reg <= epoch1_reg;
            cnt2_reg   <= cnt1_reg;
            vld2_reg   <= vld1_reg;
        end
    end

    assign tx_rom_addr  = chip_idx_reg;
    assign tx_prn       = prn2_reg;
    assign tx_sig       = sig2_reg;
    assign tx_vld       = vld2_reg;
    assign tx_chip_idx  = chip2_reg;
    assign tx_epoch     = epoch2_reg;
    assign tx_epoch_cnt = cnt2_reg;
    assign tx_load_err  = load_err_reg;

endmodule

// File: tb/tb_tmboc_code_nco_gen.sv
// Scoreboard bench for tmboc_code_nco_gen: a phase/chip/block reference model
// queues expected samples, monitors pop them as the DUT produces output.
module tb_tmboc_code_nco_gen;

    localparam int ACC_WIDTH      = 32;
    localparam int CHIP_IDX_WIDTH = 14;
    localparam int CODE_LEN       = 10;
    localparam int EPOCH_WIDTH    = 8;
    localparam longint unsigned TWO32 = 64'h1_0000_0000;

    logic                      clk = 1'b0;
    logic                      rx_rst;
    logic                      rx_en;
    logic [ACC_WIDTH-1:0]      rx_code_fcw;
    logic [1:0]                rx_mod_mode;
    logic                      rx_load;
    logic [CHIP_IDX_WIDTH-1:0] rx_load_chip;
    logic [ACC_WIDTH-1:0]      rx_load_frac;
    logic [5:0]                rx_load_blk;
    logic [CHIP_IDX_WIDTH-1:0] tx_rom_addr;
    logic                      rom_q;
    logic                      tx_prn;
    logic                      tx_sig;
    logic                      tx_vld;
    logic [CHIP_IDX_WIDTH-1:0] tx_chip_idx;
    logic                      tx_epoch;
    logic [EPOCH_WIDTH-1:0]    tx_epoch_cnt;
    logic                      tx_load_err;

    always #5 clk = ~clk;

    tmboc_code_nco_gen #(
        .ACC_WIDTH(ACC_WIDTH), .CHIP_IDX_WIDTH(CHIP_IDX_WIDTH),
        .CODE_LEN(CODE_LEN), .EPOCH_WIDTH(EPOCH_WIDTH)
    ) dut (
        .rx_clk(clk), .rx_rst(rx_rst), .rx_en(rx_en), .rx_code_fcw(rx_code_fcw),
        .rx_mod_mode(rx_mod_mode), .rx_load(rx_load), .rx_load_chip(rx_load_chip),
        .rx_load_frac(rx_load_frac), .rx_load_blk(rx_load_blk), .tx_rom_addr(tx_rom_addr),
        .rx_rom_data(rom_q), .tx_prn(tx_prn), .tx_sig(tx_sig), .tx_vld(tx_vld),
        .tx_chip_idx(tx_chip_idx), .tx_epoch(tx_epoch), .tx_epoch_cnt(tx_epoch_cnt),
        .tx_load_err(tx_load_err)
    );

    // PRN memory with registered read
    bit rom_mem [CODE_LEN];
    always @(posedge clk) rom_q <= rom_mem[int'(tx_rom_addr) % CODE_LEN];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int tgt;
        int chip;
        bit prn;
        bit sig;
        bit ep;
        int cnt;
    } exp_t;

    exp_t sq[$];
    int   eq[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    // Reference model: code phase as chip index + fraction, TMBOC block position
    int              m_chip, m_blk, m_cnt;
    longint unsigned m_frac;
    bit              m_flag;
    longint unsigned fcw_v;

    function automatic bit subcarrier(int mode, longint unsigned frac, int blk);
        bit h;
        bit s;
        longint unsigned top;
        h   = (frac >= TWO32 / 2);
        top = frac >> 24;
        s   = (((top * 12) / 256) % 2) == 1;
        case (mode)
            1:       return h;
            2:       return s;
            3:       return (blk == 0 || blk == 4 || blk == 6 || blk == 29) ? s : h;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_chip = 0; m_blk = 0; m_cnt = 0; m_frac = 0; m_flag = 0;
    endtask

    task automatic model_step();
        exp_t e;
        bit   ld_ok;
        longint unsigned sum;
        if (rx_en) begin
            e.tgt  = cyc + 2;
            e.chip = m_chip;
            e.prn  = rom_mem[m_chip];
            e.sig  = e.prn ^ subcarrier(int'(rx_mod_mode), m_frac, m_blk);
            e.ep   = m_flag;
            e.cnt  = m_cnt;
            sq.push_back(e);
        end
        ld_ok = rx_load && (int'(rx_load_chip) < CODE_LEN) && (int'(rx_load_blk) <= 32);
        if (rx_load && !ld_ok) eq.push_back(cyc + 1);
        if (ld_ok) begin
            m_chip = int'(rx_load_chip);
            m_frac = longint'(rx_load_frac);
            m_blk  = int'(rx_load_blk);
            m_flag = 0;
        end else if (rx_en) begin
            sum    = m_frac + fcw_v;
            m_flag = 0;
            m_frac = sum % TWO32;
            if (sum >= TWO32) begin
                m_blk = (m_blk + 1) % 33;
                if (m_chip == CODE_LEN - 1) begin
                    m_chip = 0;
                    m_flag = 1;
                    m_cnt  = (m_cnt + 1) % 256;
                end else begin
                    m_chip = m_chip + 1;
                end
            end
        end else begin
            m_flag = 0;
        end
    endtask

    task automatic step(input bit en, input bit [1:0] mode, input bit ld,
                        input int lc, input longint unsigned lf, input int lb);
        rx_en        = en;
        rx_mod_mode  = mode;
        rx_load      = ld;
        rx_load_chip = lc[CHIP_IDX_WIDTH-1:0];
        rx_load_frac = lf[ACC_WIDTH-1:0];
        rx_load_blk  = lb[5:0];
        rx_code_fcw  = fcw_v[ACC_WIDTH-1:0];
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input bit [1:0] mode);
        for (int i = 0; i < n; i++)
            step(1'b1, mode, 1'b0, int'($urandom_range(0, 15)), longint'($urandom), 0);
    endtask

    task automatic check_zero(input string tag);
        n_cmp++;
        if (tx_vld !== 1'b0) begin
            n_fail++; $display("FAIL %s_vld: got %0b want 0", tag, tx_vld);
        end
        n_cmp++;
        if (tx_chip_idx !== '0 || tx_rom_addr !== '0) begin
            n_fail++; $display("FAIL %s_idx: got chip=%0d addr=%0d want 0/0", tag, tx_chip_idx, tx_rom_addr);
        end
        n_cmp++;
        if (tx_epoch_cnt !== '0 || tx_epoch !== 1'b0) begin
            n_fail++; $display("FAIL %s_epoch: got ep=%0b cnt=%0d want 0/0", tag, tx_epoch, tx_epoch_cnt);
        end
        n_cmp++;
        if (tx_prn !== 1'b0 || tx_sig !== 1'b0 || tx_load_err !== 1'b0) begin
            n_fail++; $display("FAIL %s_data: got prn=%0b sig=%0b err=%0b want 0", tag, tx_prn, tx_sig, tx_load_err);
        end
        $display("reset check %s done at cyc=%0d", tag, cyc);
    endtask

    // Reset dominates a simultaneous valid load and enable
    task automatic do_reset();
        rx_rst = 1'b1; rx_en = 1'b1; rx_load = 1'b1; rx_load_chip = 3; rx_load_blk = 5;
        while (sq.size() > 0 && sq[$].tgt > cyc) void'(sq.pop_back());
        while (eq.size() > 0 && eq[$] > cyc) void'(eq.pop_back());
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_zero("rst_mid");
        @(posedge clk);
        #1;
        rx_rst = 1'b0; rx_load = 1'b0;
    endtask

    // Sample monitor
    always @(negedge clk) begin
        exp_t e;
        bit   exp_v;
        while (sq.size() > 0 && sq[0].tgt < cyc) begin
            e = sq.pop_front();
            n_cmp++; n_fail++;
            $display("FAIL sample_missing: cyc=%0d got no valid sample, want chip=%0d due at %0d", cyc, e.chip, e.tgt);
        end
        exp_v = (sq.size() > 0 && sq[0].tgt == cyc);
        if (exp_v || tx_vld) begin
            n_cmp++;
            if (!exp_v) begin
                n_fail++;
                $display("FAIL sample_unexpected: cyc=%0d got vld=1 chip=%0d, want vld=0", cyc, tx_chip_idx);
            end else begin
                e = sq.pop_front();
                if (tx_vld !== 1'b1 || int'(tx_chip_idx) != e.chip || tx_prn !== e.prn ||
                    tx_sig !== e.sig || tx_epoch !== e.ep || int'(tx_epoch_cnt) != e.cnt) begin
                    n_fail++;
                    $display("FAIL sample: cyc=%0d got vld=%0b chip=%0d prn=%0b sig=%0b ep=%0b cnt=%0d, want vld=1 chip=%0d prn=%0b sig=%0b ep=%0b cnt=%0d",
                             cyc, tx_vld, tx_chip_idx, tx_prn, tx_sig, tx_epoch, tx_epoch_cnt,
                             e.chip, e.prn, e.sig, e.ep, e.cnt);
                end else begin
                    $display("sample cyc=%0d chip=%0d prn=%0b sig=%0b ep=%0b cnt=%0d ok",
                             cyc, e.chip, e.prn, e.sig, e.ep, e.cnt);
                end
            end
        end
    end

    // Load-error monitor
    always @(negedge clk) begin
        bit exp_e;
        while (eq.size() > 0 && eq[0] < cyc) begin
            void'(eq.pop_front());
            n_cmp++; n_fail++;
            $display("FAIL load_err_missing: cyc=%0d got no pulse, want pulse", cyc);
        end
        exp_e = (eq.size() > 0 && eq[0] == cyc);
        if (exp_e || tx_load_err) begin
            n_cmp++;
            if (exp_e) void'(eq.pop_front());
            if (tx_load_err !== exp_e) begin
                n_fail++;
                $display("FAIL load_err: cyc=%0d got %0b want %0b", cyc, tx_load_err, exp_e);
            end else begin
                $display("load_err pulse cyc=%0d ok", cyc);
            end
        end
    end

    initial begin
        for (int i = 0; i < CODE_LEN; i++) rom_mem[i] = 1'($urandom);
        rx_rst = 1'b1; rx_en = 1'b0; rx_code_fcw = '0; rx_mod_mode = 2'd0;
        rx_load = 1'b0; rx_load_chip = '0; rx_load_frac = '0; rx_load_blk = '0;
        fcw_v = 64'h4000_0000;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_zero("rst_init");
        @(posedge clk);
        #1;
        rx_rst = 1'b0;

        // BPSK: chip steps every 4 samples, epoch every 40
        run(130, 2'd0);
        // BOC(1,1)
        run(40, 2'd1);
        // Load onto the last chip, wrap on the next advance
        step(1'b1, 2'd0, 1'b1, CODE_LEN - 1, TWO32 - 64'h4000_0000, 7);
        run(12, 2'd1);
        // Rejected loads and the block boundary
        step(1'b1, 2'd1, 1'b1, CODE_LEN, 0, 0);
        run(3, 2'd1);
        step(1'b1, 2'd2, 1'b1, 2, 0, 33);
        run(3, 2'd2);
        step(1'b1, 2'd2, 1'b1, 0, 0, 32);
        run(10, 2'd3);
        // Hold for 5 cycles mid-chip
        step(1'b1, 2'd0, 1'b1, 4, 64'h2000_0000, 3);
        run(1, 2'd1);
        for (int i = 0; i < 5; i++) step(1'b0, 2'd1, 1'b0, 0, 0, 0);
        run(10, 2'd1);
        // TMBOC at 64 samples/chip over a full 33-chip block
        fcw_v = 64'h0400_0000;
        step(1'b1, 2'd3, 1'b1, 0, 0, 0);
        run(64 * 34, 2'd3);
        do_reset();

        // Randomised operation
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                case ($urandom_range(0, 3))
                    0: fcw_v = longint'($urandom_range(0, 32'h7FFF_FFFF));
                    1: fcw_v = 64'h7FFF_FFFF;
                    2: fcw_v = 64'h4000_0000;
                    default: fcw_v = longint'($urandom_range(0, 32'h00FF_FFFF));
                endcase
            end
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) != 0, 2'($urandom_range(0, 3)),
                     $urandom_range(0, 19) == 0, int'($urandom_range(0, 15)),
                     longint'($urandom), int'($urandom_range(0, 40)));
            end
        end
        do_reset();
        run(8, 2'd3);

        for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 1'b0, 0, 0, 0);
        @(negedge clk);
        #1;
        n_cmp++;
        if (sq.size() != 0 || eq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d samples and %0d errors outstanding, want 0/0", sq.size(), eq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
